// File: rtl/serial_bin_pkg.sv
// Shared types and helpers for the serial binary transmitter.
// Holds the FSM state encoding, the mod-5 remainder type and the
// single-step remainder update used by both RTL and the bench model.
package serial_bin_pkg;

    localparam int unsigned MOD = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef logic [2:0] rem_t;

    // (2*r + b) mod 5 for r in 0..4; the 4-bit sum peaks at 9, so one
    // conditional subtract is enough.
    function automatic rem_t mod5_step(rem_t r, logic b);
        logic [3:0] t;
        t = {r, 1'b0} + 4'(b);
        if (t >= 4'(MOD)) begin
            t = t - 4'(MOD);
        end
        return t[2:0];
    endfunction

endpackage

// File: rtl/mod5_tracker.sv
// Running mod-5 remainder of an MSB-first serial bit stream.
// Ports: clk, rst_n (async, active-low), clr (zero the remainder),
// en (fold bit_in into the remainder), bit_in, rem (registered, 0..4).
module mod5_tracker
    import serial_bin_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [2:0] rem
);

    rem_t rem_q;
    rem_t rem_d;

    // Clear wins over a step so a new frame always starts from zero.
    always_comb begin
        rem_d = rem_q;
        if (clr) begin
            rem_d = '0;
        end else if (en) begin
            rem_d = mod5_step(rem_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/serial_bin_tx.sv
// Parallel-to-serial transmitter feeding the divisibility-by-5 detector.
// Loads a len-bit operand and sends it MSB-first, one bit per clock,
// while tracking the mod-5 remainder of the bits already sent.
// Ports: clk, rst_n; start/data_in/len (frame request, taken in IDLE);
// abort (cancel during SHIFT); ready (IDLE decode); serial_op/serial_vld/
// sof (registered bit stream); done (pulse after last bit); rem (running
// remainder); div5 (rem==0 qualified by done).
module serial_bin_tx
    import serial_bin_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             ready,
    output logic             serial_op,
    output logic             serial_vld,
    output logic             sof,
    output logic             done,
    output logic [2:0]       rem,
    output logic             div5
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] S_DONE  = 2'(ST_DONE);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             vld_q, vld_d;
    logic             sof_q, sof_d;
    logic             done_q, done_d;

    logic             len_ok_c;
    logic [WIDTH-1:0] load_val_c;
    logic             trk_clr_c;
    logic             trk_en_c;

    // Operand shifted so bit len-1 sits at the MSB; upper garbage drops off.
    assign len_ok_c   = (len != '0) && (32'(len) <= WIDTH);
    assign load_val_c = data_in << (LEN_W'(WIDTH) - len);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        op_d      = 1'b0;
        vld_d     = 1'b0;
        sof_d     = 1'b0;
        done_d    = 1'b0;
        trk_clr_c = 1'b0;
        trk_en_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && len_ok_c) begin
                    // First bit goes straight to the output flop; the
                    // shift register keeps only the bits still to come.
                    state_d   = S_SHIFT;
                    op_d      = load_val_c[WIDTH-1];
                    sreg_d    = load_val_c << 1;
                    cnt_d     = len;
                    vld_d     = 1'b1;
                    sof_d     = 1'b1;
                    trk_clr_c = 1'b1;
                end
            end
            S_SHIFT: begin
                // The bit on the wire this cycle is counted even on abort.
                trk_en_c = 1'b1;
                cnt_d    = cnt_q - LEN_W'(1);
                if (abort) begin
                    state_d = S_IDLE;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    op_d   = sreg_q[WIDTH-1];
                    sreg_d = sreg_q << 1;
                    vld_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            done_q  <= done_d;
        end
    end

    mod5_tracker u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (trk_clr_c),
        .en     (trk_en_c),
        .bit_in (op_q),
        .rem    (rem)
    );

    assign ready      = (state_q == S_IDLE);
    assign serial_op  = op_q;
    assign serial_vld = vld_q;
    assign sof        = sof_q;
    assign done       = done_q;
    assign div5       = done_q && (rem == 3'd0);

endmodule

// File: tb/tb_serial_bin_tx.sv
// Self-checking bench for serial_bin_tx: table-driven frames with a bit
// scoreboard and a reference remainder tracker, plus reset, invalid-length
// and back-to-back sequences.
module tb_serial_bin_tx;
    import serial_bin_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [LEN_W-1:0] len = '0;
    logic             ready, serial_op, serial_vld, sof, done, div5;
    logic [2:0]       rem;

    logic       ref_clr = 1'b0;
    logic       ref_en = 1'b0;
    logic       ref_bit = 1'b0;
    logic [2:0] ref_rem;

    int total = 0;
    int bad = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         abort_k;   // index of last bit sent before abort, -1 = none
        logic [2:0] exp_rem;
        logic       exp_div5;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    serial_bin_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .len        (len),
        .abort      (abort),
        .ready      (ready),
        .serial_op  (serial_op),
        .serial_vld (serial_vld),
        .sof        (sof),
        .done       (done),
        .rem        (rem),
        .div5       (div5)
    );

    mod5_tracker u_ref (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ref_clr),
        .en     (ref_en),
        .bit_in (ref_bit),
        .rem    (ref_rem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_frame(input vec_t v);
        @(negedge clk);
        chk("ready_pre", 32'(ready), 32'd1);
        start   = 1'b1;
        data_in = v.data;
        len     = v.len;
        ref_clr = 1'b1;
        for (int i = int'(v.len) - 1; i >= 0; i--) exp_q.push_back(v.data[i]);
        for (int k = 0; k < int'(v.len); k++) begin
            logic eb;
            @(negedge clk);
            start   = 1'b0;
            ref_clr = 1'b0;
            chk("rem_run", 32'(rem), 32'(ref_rem));
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
                eb = 1'b0;
            end else begin
                eb = exp_q.pop_front();
            end
            chk("vld", 32'(serial_vld), 32'd1);
            chk("bit", 32'(serial_op), 32'(eb));
            chk("sof", 32'(sof), 32'(k == 0));
            chk("no_done", 32'(done), 32'd0);
            chk("busy", 32'(ready), 32'd0);
            ref_en  = 1'b1;
            ref_bit = eb;
            if (k == v.abort_k) begin
                abort = 1'b1;
                @(negedge clk);
                abort  = 1'b0;
                ref_en = 1'b0;
                chk("abort_ready", 32'(ready), 32'd1);
                chk("abort_vld", 32'(serial_vld), 32'd0);
                chk("abort_op", 32'(serial_op), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_rem", 32'(rem), 32'(v.exp_rem));
                chk("abort_ref", 32'(rem), 32'(ref_rem));
                exp_q.delete();
                return;
            end
        end
        @(negedge clk);
        ref_en = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("div5", 32'(div5), 32'(v.exp_div5));
        chk("rem_final", 32'(rem), 32'(v.exp_rem));
        chk("rem_ref", 32'(rem), 32'(ref_rem));
        chk("done_vld", 32'(serial_vld), 32'd0);
        chk("done_op", 32'(serial_op), 32'd0);
        chk("done_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_div5", 32'(div5), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_op"}, 32'(serial_op), 32'd0);
        chk({tag, "_vld"}, 32'(serial_vld), 32'd0);
        chk({tag, "_sof"}, 32'(sof), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_div5"}, 32'(div5), 32'd0);
        chk({tag, "_rem"}, 32'(rem), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sof_cnt;
        int done_cnt;
        int div_cnt;
        int sof_pos[$];

        vecs.push_back('{8'h05, 4'd3, -1, 3'd0, 1'b1});
        vecs.push_back('{8'h09, 4'd4, -1, 3'd4, 1'b0});
        vecs.push_back('{8'hFF, 4'd8, -1, 3'd0, 1'b1});
        vecs.push_back('{8'h0A, 4'd4,  1, 3'd2, 1'b0});  // bits 1,0 sent
        vecs.push_back('{8'h01, 4'd1, -1, 3'd1, 1'b0});
        vecs.push_back('{8'hF3, 4'd2, -1, 3'd3, 1'b0});  // upper bits ignored
        vecs.push_back('{8'h80, 4'd8, -1, 3'd3, 1'b0});
        vecs.push_back('{8'hA5, 4'd8, -1, 3'd0, 1'b1});

        // Reset state.
        @(negedge clk);
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_frame(vecs[i]);

        // Invalid lengths are ignored.
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'hFF;
        len     = 4'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("len0_ready", 32'(ready), 32'd1);
            chk("len0_vld", 32'(serial_vld), 32'd0);
        end
        len = 4'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("len9_ready", 32'(ready), 32'd1);
            chk("len9_vld", 32'(serial_vld), 32'd0);
        end
        start = 1'b0;

        // Frame after a rejected request still works.
        run_frame('{8'h05, 4'd3, -1, 3'd0, 1'b1});

        // Asynchronous reset mid-frame, checked before any clock edge.
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'h07;
        len     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_vld", 32'(serial_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        run_frame('{8'h02, 4'd3, -1, 3'd2, 1'b0});

        // Start held high: one frame every len+2 = 5 cycles.
        @(negedge clk);
        start   = 1'b1;
        data_in = 8'h05;
        len     = 4'd3;
        sof_cnt = 0;
        done_cnt = 0;
        div_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sof) begin
                sof_cnt++;
                sof_pos.push_back(c);
            end
            if (done) done_cnt++;
            if (div5) div_cnt++;
        end
        start = 1'b0;
        chk("b2b_sof_cnt", 32'(sof_cnt), 32'd4);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd4);
        chk("b2b_div5_cnt", 32'(div_cnt), 32'd4);
        foreach (sof_pos[i]) chk("b2b_sof_pos", 32'(sof_pos[i]), 32'(5 * i));
        @(negedge clk);
        chk("b2b_idle", 32'(ready), 32'd1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
